// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - RV32I fetch stage: owns fetch PC, buffers {pc, inst} pairs for decode.
// Optional FETCH_BYPASS_EN: an empty queue forwards the memory word to decode in the same cycle.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [31:0] fetch_pc_out
);
    localparam int              AW     = $clog2(DEPTH);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          fifo_valid;
    logic          bypass;
    logic          bypass_take;
    logic          pop;
    logic          push;
    logic          unused_redirect_lsbs;

    // RV32I has no compressed instructions, so the target's low bits are dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr    = pc_q;
    assign fetch_pc_out = pc_q;
    assign fifo_valid   = (cnt_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = ~fifo_valid & ~redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_take = bypass & dec_ready;
    assign pop         = fifo_valid & dec_ready & ~redirect_valid;
    assign push        = ~redirect_valid & ~bypass_take & ((cnt_q != FULL_C) | pop);

    always_comb begin
        dec_valid = 1'b0;
        dec_inst  = '0;
        dec_pc    = '0;
        if (fifo_valid) begin
            dec_valid = 1'b1;
            dec_inst  = inst_mem[rd_q];
            dec_pc    = pc_mem[rd_q];
        end else if (bypass) begin
            dec_valid = 1'b1;
            dec_inst  = imem_inst;
            dec_pc    = pc_q;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            pc_d  = {redirect_pc[31:2], 2'b00};
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push || bypass_take) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem[wr_q] <= imem_inst;
            pc_mem[wr_q]   <= pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue with a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic [31:0] imem_addr, imem_inst, dec_inst, dec_pc, fetch_pc_out;
    logic        dec_valid;

    logic        rst1 = 1'b1;
    logic        ready1 = 1'b0;
    logic [31:0] imem_addr1, imem_inst1, dec_inst1, dec_pc1, fetch_pc_out1;
    logic        dec_valid1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0313;
        if (a == 32'h4) return 32'h0063_0333;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_inst  = mem_word(imem_addr);
    assign imem_inst1 = mem_word(imem_addr1);

    fetch_queue #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u0 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .fetch_pc_out(fetch_pc_out)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u1 (
        .clk(clk), .rst(rst1), .imem_addr(imem_addr1), .imem_inst(imem_inst1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .dec_valid(dec_valid1), .dec_ready(ready1), .dec_inst(dec_inst1),
        .dec_pc(dec_pc1), .fetch_pc_out(fetch_pc_out1)
    );

    logic [31:0] qpc[$];
    logic [31:0] qinst[$];
    logic [31:0] mpc;
    bit          model_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
        bit          byp, ev, pop, push;
        logic [31:0] epc, einst;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rp; dec_ready = rdy;
        #1;
        if (model_ok) begin
            byp   = BYP && qpc.size() == 0 && !rv;
            ev    = qpc.size() != 0 || byp;
            epc   = qpc.size() != 0 ? qpc[0]   : (byp ? mpc : 32'h0);
            einst = qpc.size() != 0 ? qinst[0] : (byp ? mem_word(mpc) : 32'h0);
            chk("dec_valid", {31'h0, dec_valid}, {31'h0, ev});
            chk("dec_pc", dec_pc, epc);
            chk("dec_inst", dec_inst, einst);
            chk("imem_addr", imem_addr, mpc);
            chk("fetch_pc_out", fetch_pc_out, mpc);
        end else begin
            byp = 1'b0;
            ev  = 1'b0;
        end
        if (r) begin
            qpc.delete(); qinst.delete(); mpc = 32'h0; model_ok = 1'b1;
        end else if (rv) begin
            qpc.delete(); qinst.delete(); mpc = rp & ~32'h3;
        end else if (byp && rdy) begin
            mpc = mpc + 32'd4;
        end else begin
            pop  = qpc.size() != 0 && rdy;
            push = qpc.size() < DEPTH || pop;
            if (pop) begin
                void'(qpc.pop_front()); void'(qinst.pop_front());
            end
            if (push) begin
                qpc.push_back(mpc); qinst.push_back(mem_word(mpc)); mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] seen[$];

        // Startup
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
`ifdef FETCH_BYPASS_EN
        chk("byp_first_valid", {31'h0, dec_valid}, 32'h1);
        chk("byp_first_pc", dec_pc, 32'h0);
        chk("byp_first_inst", dec_inst, 32'h0010_0313);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            chk("byp_model_count", qpc.size(), 0);
        end
`else
        chk("start_c1_valid", {31'h0, dec_valid}, 32'h0);
        chk("start_c1_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("start_c2_pc", dec_pc, 32'h0);
        chk("start_c2_inst", dec_inst, 32'h0010_0313);
        step(0, 0, 0, 1);
        chk("start_c3_pc", dec_pc, 32'h4);
        chk("start_c3_inst", dec_inst, 32'h0063_0333);
`endif

        // Backpressure then drain
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        chk("bp_model_count", qpc.size(), 4);
        chk("bp_imem_addr", imem_addr, 32'h10);
        chk("bp_head_pc", dec_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
            chk("drain_pc", dec_pc, 32'(i * 4));
            chk("drain_valid", {31'h0, dec_valid}, 32'h1);
        end

        // Redirect while full
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("full_model_count", qpc.size(), 4);
        step(0, 1, 32'h43, 1);
        chk("redir_presented", {31'h0, dec_valid}, 32'h1);
        step(0, 0, 0, 0);
        chk("redir_addr", imem_addr, 32'h40);
`ifndef FETCH_BYPASS_EN
        chk("redir_valid_low", {31'h0, dec_valid}, 32'h0);
`endif
        step(0, 0, 0, 0);
        chk("redir_head_pc", dec_pc, 32'h40);

        // Reset with count 3 and a concurrent redirect
        step(0, 0, 0, 0);
        chk("mid_model_count", qpc.size(), 3);
        step(1, 1, 32'h80, 1);
        step(0, 0, 0, 0);
        chk("mid_rst_addr", imem_addr, 32'h0);
`ifndef FETCH_BYPASS_EN
        chk("mid_rst_valid", {31'h0, dec_valid}, 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 $urandom, ($urandom_range(0, 3) != 0));
        end

        // PC wrap on the second instance
        @(negedge clk); rst1 = 1'b1; ready1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (dec_valid1) seen.push_back(dec_pc1);
            if (dec_valid1 && dec_pc1 == 32'h0) chk("wrap_inst0", dec_inst1, 32'h0010_0313);
            @(negedge clk);
        end
        chk("wrap_seen", seen.size() >= 3, 1);
        if (seen.size() >= 3) begin
            chk("wrap_pc0", seen[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", seen[1], 32'h0);
            chk("wrap_pc2", seen[2], 32'h4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage of the RV32I core.
- Owns the fetch PC and drives the word address into the combinational, byte-addressed instruction memory.
- Captures each returned 32-bit word together with its PC into a small FIFO.
- Presents FIFO entries to decode with a valid/ready handshake and flushes on branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc
- imem_inst  input  32  instruction word returned combinationally for imem_addr
- redirect_valid  input  1  execute requests PC change (taken branch/jump)
- redirect_pc  input  32  redirect target byte address
- dec_valid  output  1  head entry valid for decode
- dec_ready  input  1  decode accepts head entry this cycle
- dec_inst  output  32  head instruction word
- dec_pc  output  32  PC of head instruction
- fetch_pc_out  output  32  current fetch_pc, for debug

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst, sampled on the rising edge only.
- Reset values:
  - fetch_pc = RESET_PC; FIFO count, read pointer and write pointer = 0.
  - dec_valid = 0; dec_inst = 0; dec_pc = 0.
  - imem_addr = RESET_PC.
- imem_addr: combinational copy of fetch_pc.
- Pop condition: pop = dec_valid & dec_ready & ~redirect_valid.
- Push condition: push = ~redirect_valid & (count < DEPTH | pop).
  - A push while full is allowed only with a simultaneous pop.
  - A push writes {fetch_pc, imem_inst} at the write pointer; fetch_pc <= fetch_pc + 4.
- Stall: if not pushing and not redirecting, fetch_pc holds and imem_addr is stable.
- count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Pointers: increment modulo DEPTH and wrap silently.
- Redirect (highest priority below rst), next edge:
  - count, read and write pointers cleared; no push; no pop.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}. Low two bits are ignored because RV32I has no compressed instructions.
- Redirect while FIFO empty, full, or mid-handshake: same flush behaviour. An entry presented that cycle is not consumed, and decode must ignore it.
- Outputs: dec_valid = (count != 0). dec_inst/dec_pc come from the head entry when valid and are driven 0 when dec_valid = 0.
- Latency (feature off): word at fetch_pc appears on dec_* one cycle after the push edge. Sustained throughput is 1 instruction/cycle with dec_ready held high.
- PC arithmetic: 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
- rst asserted mid-operation: all state returns to reset values on that edge regardless of redirect/handshake inputs.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when count == 0 and redirect_valid == 0, the outputs bypass the FIFO:
  - dec_valid = 1, dec_inst = imem_inst, dec_pc = fetch_pc, combinationally.
  - If dec_ready = 1, the word is consumed directly: no FIFO write, fetch_pc advances by 4, count stays 0.
  - If dec_ready = 0, the word is pushed normally.
  - This gives zero-cycle fetch-to-decode latency.
- Not defined: dec_valid is strictly (count != 0) and all words pass through the FIFO, giving one-cycle latency.

Test Plan:
- Startup, feature off: memory model holds 32'h00100313 at 0x0 and 32'h00630333 at 0x4; release rst with dec_ready=1 -> cycle 1 dec_valid=0; cycle 2 dec_valid=1, dec_pc=0x0, dec_inst=32'h00100313; cycle 3 dec_pc=0x4, dec_inst=32'h00630333.
- Backpressure: dec_ready=0 for 8 cycles after reset -> count saturates at 4 with PCs 0x0..0xC; imem_addr holds 0x10; raising dec_ready drains 0x0,0x4,0x8,0xC then 0x10 with no gaps.
- Redirect while full: FIFO full, assert redirect_valid with redirect_pc=0x43 and dec_ready=1 -> next cycle count=0, dec_valid=0, imem_addr=0x40, no entry consumed; following cycle dec_pc=0x40.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, dec_ready=1 -> dec_pc sequence 0xFFFFFFFC, 0x0, 0x4.
- Reset mid-operation: count=3 with redirect_valid and rst both asserted -> next cycle dec_valid=0, imem_addr=RESET_PC, count=0.
- FETCH_BYPASS_EN defined: first cycle after reset with dec_ready=1 -> dec_valid=1, dec_pc=0x0, dec_inst=32'h00100313 in the same cycle; count remains 0 throughout a 10-cycle free run.
